// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared types and constants for the snake body tracker:
//            heading enum, board coordinate struct, board/length sizes,
//            reset head/tail positions and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam int GRID    = 16;
    localparam int MAX_LEN = 16;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic [3:0] i;  // row
        logic [3:0] j;  // column
    } pos_t;

    localparam pos_t C_INIT_HEAD = '{i: 4'd7, j: 4'd4};
    localparam pos_t C_INIT_TAIL = '{i: 4'd7, j: 4'd3};

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DEAD = 2'd2;

    // Opposite headings differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (2'(a) ^ 2'(b)) == 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_next_pos.sv
`default_nettype none
// ============================================================================
// Module   : snake_next_pos
// Purpose  : Combinational one-cell step of a board position plus wall check.
// Ports    : pos_i       - current position
//            dir_i       - heading to step in
//            next_pos_o  - stepped position (value meaningless if off board)
//            off_board_o - step would leave the board
// Revision : 1.0 - initial release
// ============================================================================
module snake_next_pos
    import snake_pkg::*;
(
    input  pos_t pos_i,
    input  dir_t dir_i,
    output pos_t next_pos_o,
    output logic off_board_o
);

    always_comb begin
        next_pos_o  = pos_i;
        off_board_o = 1'b0;
        case (dir_i)
            UP: begin
                next_pos_o.i = pos_i.i - 4'd1;
                off_board_o  = (pos_i.i == 4'd0);
            end
            DOWN: begin
                next_pos_o.i = pos_i.i + 4'd1;
                off_board_o  = (pos_i.i == 4'(GRID - 1));
            end
            LEFT: begin
                next_pos_o.j = pos_i.j - 4'd1;
                off_board_o  = (pos_i.j == 4'd0);
            end
            RIGHT: begin
                next_pos_o.j = pos_i.j + 4'd1;
                off_board_o  = (pos_i.j == 4'(GRID - 1));
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/snake_body.sv
`default_nettype none
// ============================================================================
// Module   : snake_body
// Purpose  : Snake body tracker. Segments live in a circular buffer with
//            head/tail pointers; a registered bitmap mirrors occupancy and
//            doubles as the self-collision lookup.
// Ports    : clk, reset (sync, active-low)
//            tick             - advance one cell
//            dir_valid, dir   - heading request (reverse requests dropped)
//            i_apple, j_apple - apple position
//            GrnPixels        - body bitmap [row][col]
//            eaten            - one-cycle pulse after the head lands on apple
//            game_over        - high in DEAD
//            length           - segment count
// Revision : 1.0 - initial release
// ============================================================================
module snake_body #(
    parameter int GRID    = snake_pkg::GRID,
    parameter int MAX_LEN = snake_pkg::MAX_LEN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic                           dir_valid,
    input  logic [1:0]                     dir,
    input  logic [3:0]                     i_apple,
    input  logic [3:0]                     j_apple,
    output logic [GRID-1:0][GRID-1:0]      GrnPixels,
    output logic                           eaten,
    output logic                           game_over,
    output logic [4:0]                     length
);

    import snake_pkg::*;

    localparam int         PTR_W     = $clog2(MAX_LEN);
    localparam logic [4:0] C_MAX_LEN = 5'(MAX_LEN);

    logic [1:0]               state_q, state_d;
    dir_t                     heading_q, heading_d;
    pos_t                     seg_q [MAX_LEN];
    logic [PTR_W-1:0]         head_ptr_q, tail_ptr_q;
    logic [4:0]               len_q;
    logic [GRID-1:0][GRID-1:0] grid_q, grid_d;
    logic                     eaten_q;

    dir_t w_dir_req, w_step_dir;
    pos_t w_head, w_tail, w_next, w_apple;
    logic w_off, w_eat, w_grow, w_self, w_collide, w_move;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    // A same-cycle request steers this very step.
    assign w_dir_req  = dir_t'(dir);
    assign w_step_dir = (dir_valid && !is_reverse(w_dir_req, heading_q)) ? w_dir_req : heading_q;
    assign w_head     = seg_q[head_ptr_q];
    assign w_tail     = seg_q[tail_ptr_q];
    assign w_apple    = '{i: i_apple, j: j_apple};

    snake_next_pos u_next_pos (
        .pos_i       (w_head),
        .dir_i       (w_step_dir),
        .next_pos_o  (w_next),
        .off_board_o (w_off)
    );

    assign w_eat  = (w_next == w_apple);
    // At full length eating no longer grows; the tail still advances.
    assign w_grow = w_eat && (len_q < C_MAX_LEN);
    // The tail cell is free to enter only when the tail is moving away.
    assign w_self    = grid_q[w_next.i][w_next.j] && !((w_next == w_tail) && !w_grow);
    assign w_collide = w_off || w_self;
    assign w_move    = (state_q == C_ST_RUN) && tick && !w_collide;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) state_q <= C_ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (dir_valid)          state_d = C_ST_RUN;
            C_ST_RUN:  if (tick && w_collide)  state_d = C_ST_DEAD;
            C_ST_DEAD:                         state_d = C_ST_DEAD;
            default:                           state_d = C_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        game_over = (state_q == C_ST_DEAD);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        heading_d = heading_q;
        if (state_q != C_ST_DEAD && dir_valid && !is_reverse(w_dir_req, heading_q))
            heading_d = w_dir_req;

        // Clear before set so a head entering the vacated tail cell stays lit.
        grid_d = grid_q;
        if (w_move) begin
            if (!w_grow) grid_d[w_tail.i][w_tail.j] = 1'b0;
            grid_d[w_next.i][w_next.j] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < MAX_LEN; k++) seg_q[k] <= '0;
            seg_q[0]   <= C_INIT_TAIL;
            seg_q[1]   <= C_INIT_HEAD;
            tail_ptr_q <= '0;
            head_ptr_q <= PTR_W'(1);
            len_q      <= 5'd2;
            heading_q  <= RIGHT;
            eaten_q    <= 1'b0;
            grid_q     <= '0;
            grid_q[C_INIT_TAIL.i][C_INIT_TAIL.j] <= 1'b1;
            grid_q[C_INIT_HEAD.i][C_INIT_HEAD.j] <= 1'b1;
        end else begin
            heading_q <= heading_d;
            grid_q    <= grid_d;
            eaten_q   <= w_move && w_eat;
            if (w_move) begin
                seg_q[ptr_inc(head_ptr_q)] <= w_next;
                head_ptr_q                 <= ptr_inc(head_ptr_q);
                if (w_grow) len_q      <= len_q + 5'd1;
                else        tail_ptr_q <= ptr_inc(tail_ptr_q);
            end
        end
    end

    assign GrnPixels = grid_q;
    assign eaten     = eaten_q;
    assign length    = len_q;

endmodule
`default_nettype wire

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter: GRID, 16, board edge length in cells.
REQ-002 Parameter: MAX_LEN, 16, maximum snake length in segments.
REQ-003 Port: clk  input  1  system clock; all state changes on posedge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 Port: tick  input  1  move strobe; one step per cycle in which tick=1.
REQ-006 Port: dir_valid  input  1  qualifies dir.
REQ-007 Port: dir  input  2  requested heading (dir_t).
REQ-008 Port: i_apple  input  4  apple row, from the apple spawner.
REQ-009 Port: j_apple  input  4  apple column, from the apple spawner.
REQ-010 Port: GrnPixels  output  [15:0][15:0]  registered body bitmap, GrnPixels[i][j]=1 when a segment occupies row i, column j.
REQ-011 Port: eaten  output  1  one-cycle pulse to the apple spawner when the head lands on the apple.
REQ-012 Port: game_over  output  1  high while in DEAD.
REQ-013 Port: length  output  5  current segment count, 2..MAX_LEN.

Function
REQ-014 The block SHALL store segment coordinates in a circular buffer of MAX_LEN entries with head and tail pointers, and GrnPixels SHALL always equal the set of occupied entries.
REQ-015 States SHALL be IDLE, RUN and DEAD: IDLE->RUN on the first dir_valid; RUN->DEAD on collision; DEAD holds until reset.
REQ-016 In IDLE and DEAD, tick SHALL be ignored and no outputs other than state-driven ones SHALL change.
REQ-017 dir_valid SHALL update the heading register unless dir is the exact reverse of the current heading, in which case the request is dropped.
REQ-018 When dir_valid and tick coincide, the new heading SHALL apply to that same step.
REQ-019 On tick in RUN, next head = head stepped by one cell: UP i-1, DOWN i+1, LEFT j-1, RIGHT j+1.
REQ-020 A step leaving the board (i or j outside 0..GRID-1, i.e. 4-bit wrap) SHALL be a wall collision; coordinates SHALL NOT wrap.
REQ-021 A next head on an occupied cell SHALL be a self collision, except on the current tail cell when not growing, since the tail vacates that cell in the same step.
REQ-022 A collision SHALL enter DEAD with the body, GrnPixels and length frozen and eaten not asserted; collision SHALL take priority over eating.
REQ-023 A next head equal to (i_apple, j_apple) SHALL assert eaten for exactly the cycle after the tick and grow by one: the head advances and the tail holds.
REQ-024 At length = MAX_LEN, eating SHALL still pulse eaten, but the tail SHALL advance and length SHALL saturate.
REQ-025 Without eating, the head and tail SHALL both advance one entry and length SHALL be unchanged.
REQ-026 GrnPixels, length and game_over SHALL reflect a step on the cycle after tick is sampled (latency 1).
REQ-027 Pointers SHALL wrap modulo MAX_LEN.

Reset
REQ-028 When reset=0 at posedge clk, the block SHALL enter IDLE, heading RIGHT, length=2, tail=(7,3), head=(7,4), GrnPixels with only bits [7][3] and [7][4] set, eaten=0 and game_over=0.
REQ-029 Reset asserted mid-move or while DEAD SHALL take priority over tick and dir_valid in the same cycle.

Structure
REQ-030 Package snake_pkg SHALL hold the dir_t enum (UP=0, DOWN=1, LEFT=2, RIGHT=3), the pos_t struct {i,j 4-bit}, GRID, MAX_LEN and the initial head/tail constants.
REQ-031 The combinational next-position and wall check SHALL be a sub-module snake_next_pos (inputs pos and dir; outputs next pos and off_board).

Verification
REQ-032 Reset, then dir_valid=1 with dir=RIGHT and 3 ticks (apple at (10,14)) -> head (7,7), GrnPixels bits [7][6],[7][7] only, length=2, eaten never high.
REQ-033 Apple at (7,5), one tick from reset position -> eaten=1 for exactly one cycle, length=3, bits [7][3],[7][4],[7][5] set.
REQ-034 dir_valid with dir=LEFT while heading RIGHT, then tick -> request ignored; head moves to (7,5).
REQ-035 Head at (7,15) heading RIGHT, tick -> game_over=1; GrnPixels unchanged; further ticks have no effect until reset=0.
REQ-036 Snake of length 4 driven in a tight square so the head enters the just-vacated tail cell -> no collision; entering any other body cell -> game_over=1.
REQ-037 Grow to MAX_LEN=16, then eat once more -> eaten pulses, length stays 16, popcount(GrnPixels)=16.
